apb_xfer_ctrl_0: RTL and testbench
==================================

APB_XFER_CTRL_0 -- requirements
Module: apb_xfer_ctrl_0

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- SLAVE_NUM, 5, number of APB slaves; width of ss and psel.
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles waiting for pready (range 1..255).

REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- pclk, in, 1, single clock; all state changes on its rising edge.
- presetn, in, 1, synchronous active-low reset.
- req_valid, in, 1, transfer request from the bridge.
- req_ready, out, 1, request accepted.
- req_addr, in, ADDR_WIDTH, target address.
- req_write, in, 1, 1 = write, 0 = read.
- req_wdata, in, DATA_WIDTH, write data.
- req_strb, in, DATA_WIDTH/8, write strobes.
- req_prot, in, 3, protection attributes.
- ss, in, SLAVE_NUM, one-hot slave select from the address decoder, combinationally valid for req_addr.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_rdata, out, DATA_WIDTH, read data.
- rsp_err, out, 1, slave error, decode error, or timeout.
- psel, out, SLAVE_NUM, APB selects.
- penable, out, 1, APB enable.
- paddr, out, ADDR_WIDTH, APB address.
- pwrite, out, 1, APB write.
- pwdata, out, DATA_WIDTH, APB write data.
- pstrb, out, DATA_WIDTH/8, APB strobes.
- pprot, out, 3, APB protection.
- prdata, in, SLAVE_NUM*DATA_WIDTH, concatenated per-slave read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- pready, in, SLAVE_NUM, per-slave ready.
- pslverr, in, SLAVE_NUM, per-slave error.

Function
REQ-003 The FSM SHALL have the states IDLE, SETUP, ACCESS, DECERR and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-005 On acceptance, the block SHALL register req_addr, req_write, req_wdata, req_strb, req_prot and ss. paddr, pwrite, pwdata, pstrb and pprot SHALL hold these values until the next acceptance.
REQ-006 On acceptance, the next state SHALL be SETUP when the sampled ss has exactly one bit set. It SHALL be DECERR when ss is zero or has more than one bit set.
REQ-007 In SETUP, psel SHALL equal the registered ss and penable SHALL be 0. SETUP SHALL always last one cycle and then go to ACCESS.
REQ-008 In ACCESS, psel SHALL equal the registered ss and penable SHALL be 1.
- The selected slave's pready, pslverr and prdata are those indexed by the registered ss.
- When the selected pready is 1: capture its prdata (reads only; 0 for writes) into rsp_rdata, set rsp_err to the selected pslverr, and go to RESP.
REQ-009 pready, pslverr and prdata of non-selected slaves SHALL be ignored.
REQ-010 A timeout counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with the selected pready = 0.
- If the counter reaches TIMEOUT_CYCLES-1 and pready is still 0, the transfer SHALL terminate: go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Total ACCESS cycles SHALL never exceed TIMEOUT_CYCLES.
REQ-011 DECERR SHALL last one cycle with psel = 0 and penable = 0, then go to RESP with rsp_err = 1 and rsp_rdata = 0.
REQ-012 In RESP, rsp_valid SHALL be 1 and psel/penable SHALL be 0.
- rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready, then go to IDLE.
- rsp_ready = 1 on the first RESP cycle SHALL give a single-cycle RESP.
REQ-013 Minimum latency SHALL be as follows:
- Acceptance at edge N, with pready = 1 on the first ACCESS cycle: rsp_valid SHALL be 1 in cycle N+3.
- Decode error: rsp_valid SHALL be 1 in cycle N+2.
REQ-014 At most one transfer SHALL be outstanding; there SHALL be no request pipelining.
REQ-015 psel SHALL be zero or one-hot in every cycle.

Reset
REQ-016 presetn = 0 sampled at a rising edge SHALL force IDLE regardless of current state, including mid-ACCESS (the transfer is abandoned and no response is issued).
REQ-017 The following reset values SHALL apply from the next cycle:
- psel = 0, penable = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
- paddr, pwdata, pstrb, pprot, pwrite = 0.
- timeout counter = 0.
- req_ready = 1 after reset deasserts.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Read at 0x0000_0010 with ss = 5'b00001 and pready = 1 immediately -> psel[0] high for 2 cycles; penable in the 2nd; rsp_rdata = prdata slice 0 (e.g. 0xDEAD_BEEF); rsp_err = 0; rsp_valid at N+3.
- Write to slave 3 with ss = 5'b01000, pready delayed 3 cycles, then pslverr[3] = 1 -> pwdata and pstrb stable throughout; 4 ACCESS cycles; rsp_err = 1; rsp_rdata = 0.
- ss = 5'b00000 (unmapped address 0x0005_0000) -> psel stays 0; rsp_err = 1 at N+2.
- ss = 5'b00110 (overlapping ranges) -> DECERR; no psel asserted.
- Selected pready held 0 with TIMEOUT_CYCLES = 16 -> exactly 16 ACCESS cycles; then RESP with rsp_err = 1.
- presetn pulled low in the 2nd ACCESS cycle -> all outputs at reset values next cycle; no rsp_valid; a new request is then accepted normally.

Source files
------------

// File: rtl/apb_xfer_ctrl_0.sv
// apb_xfer_ctrl_0: single-outstanding APB master transfer controller.
// Accepts one request from the bridge, runs the APB SETUP/ACCESS phases on
// the slave picked by the one-hot ss vector, then holds the response
// until the bridge consumes it. Illegal selects (none or several slaves)
// short-circuit to a decode-error response without touching the bus.
//
// Handshakes: both req (req_valid/req_ready) and rsp (rsp_valid/rsp_ready)
// transfer exactly on a rising pclk edge where valid && ready are both 1;
// the payload must be stable while valid is high and ready is low, and
// ready never depends combinationally on valid.
module apb_xfer_ctrl_0 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVE_NUM      = 5,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            pclk,
  input  logic                            presetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic                            req_write,
  input  logic [DATA_WIDTH-1:0]           req_wdata,
  input  logic [DATA_WIDTH/8-1:0]         req_strb,
  input  logic [2:0]                      req_prot,
  input  logic [SLAVE_NUM-1:0]            ss,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic [SLAVE_NUM-1:0]            psel,
  output logic                            penable,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic                            pwrite,
  output logic [DATA_WIDTH-1:0]           pwdata,
  output logic [DATA_WIDTH/8-1:0]         pstrb,
  output logic [2:0]                      pprot,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] prdata,
  input  logic [SLAVE_NUM-1:0]            pready,
  input  logic [SLAVE_NUM-1:0]            pslverr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DECERR = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Current FSM state; kept as a plainly named register so checkers can
  // bind to it hierarchically.
  state_t state;

  // Select vector captured at acceptance; indexes the slave return muxes.
  logic [SLAVE_NUM-1:0] ss_q;

  // Counts ACCESS cycles spent with the selected pready low.
  logic [7:0] tcnt;

  // Last permitted wait count: ACCESS ends on the cycle tcnt reaches this.
  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // Pick the selected slave's return signals; others are masked off by ss_q.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (ss_q[i]) begin
        sel_ready = sel_ready | pready[i];
        sel_err   = sel_err | pslverr[i];
        sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Transfer FSM with all bus and response outputs registered.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      ss_q      <= '0;
      tcnt      <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            ss_q      <= ss;
            paddr     <= req_addr;
            pwrite    <= req_write;
            pwdata    <= req_wdata;
            pstrb     <= req_strb;
            pprot     <= req_prot;
            if ($onehot(ss)) begin
              psel  <= ss;
              state <= SETUP;
            end else begin
              // Zero or multiple selects: never drive psel for this request.
              psel  <= '0;
              state <= DECERR;
            end
          end
        end

        SETUP: begin
          penable <= 1'b1;
          tcnt    <= '0;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= pwrite ? '0 : sel_rdata;
            state     <= RESP;
          end else if (tcnt == TLAST) begin
            // Slave never answered: end the transfer with an error.
            psel      <= '0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end

        DECERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          psel      <= '0;
          penable   <= 1'b0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_xfer_ctrl_0.sv
// Testbench for apb_xfer_ctrl_0: directed scenarios plus a randomized
// back-to-back run. Responses are predicted when a request is driven and
// checked by a scoreboard on each rsp handshake.
// Cycle numbering: the request is accepted at edge N; "cycle N+k" is the
// cycle ending at edge N+k, observed at 2 ns after edge N+k-1.
module tb_apb_xfer_ctrl_0;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SN = 5;
  localparam int TO = 16;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [AW-1:0]     req_addr = '0;
  logic              req_write = 1'b0;
  logic [DW-1:0]     req_wdata = '0;
  logic [DW/8-1:0]   req_strb = '0;
  logic [2:0]        req_prot = '0;
  logic [SN-1:0]     ss = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [SN-1:0]     psel;
  logic              penable;
  logic [AW-1:0]     paddr;
  logic              pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW/8-1:0]   pstrb;
  logic [2:0]        pprot;
  logic [SN*DW-1:0]  prdata = '0;
  logic [SN-1:0]     pready = '0;
  logic [SN-1:0]     pslverr = '0;

  apb_xfer_ctrl_0 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SLAVE_NUM(SN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_prot(req_prot), .ss(ss),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Clock
  always #5 pclk = ~pclk;

  // Scoreboard: {err, rdata} per expected response.
  logic [DW:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Observations from the last do_xfer call.
  int          obs_lat;
  int          obs_access;
  int          obs_setup;
  int          obs_resp;
  bit          obs_psel_bad;
  bit          obs_bus_bad;
  bit          obs_rsp_unstable;
  bit          obs_hang;
  logic [SN-1:0] obs_psel_or;

  // Scoreboard check on every response handshake (mid-cycle sample).
  always @(negedge pclk) begin
    if (presetn && rsp_valid && rsp_ready) begin
      logic [DW:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got err=%0b data=%h, required no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_err, rsp_rdata} !== e) begin
          bad++;
          $display("FAIL sb_rsp: got err=%0b data=%h, required err=%0b data=%h",
                   rsp_err, rsp_rdata, e[DW], e[DW-1:0]);
        end
      end
    end
  end

  // Drive one request, act as the slave set, consume the response.
  // wait_n = ACCESS cycles with selected pready low before it rises.
  // hold   = RESP cycles with rsp_ready low before it rises.
  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                         input logic [2:0] prot, input logic [SN-1:0] ssv,
                         input int wait_n, input logic slverr,
                         input logic [DW-1:0] rdata, input int hold);
    int k;
    int guard;
    bit done;
    logic [DW:0] first_rsp;
    obs_lat = 0; obs_access = 0; obs_setup = 0; obs_resp = 0;
    obs_psel_bad = 0; obs_bus_bad = 0; obs_rsp_unstable = 0; obs_hang = 0;
    obs_psel_or = '0;
    first_rsp = '0;
    @(posedge pclk); #2;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge pclk); #2;
      guard++;
    end
    req_addr = addr; req_write = wr; req_wdata = wdata; req_strb = strb;
    req_prot = prot; ss = ssv; req_valid = 1'b1;
    for (int i = 0; i < SN; i++)
      prdata[i*DW +: DW] = ssv[i] ? rdata : DW'($urandom());
    // Unselected slaves look ready and erroring; they must be ignored.
    pready  = ~ssv;
    pslverr = ~ssv | (slverr ? ssv : '0);
    if (!$onehot(ssv) || wait_n >= TO) exp_q.push_back({1'b1, {DW{1'b0}}});
    else exp_q.push_back({slverr, (wr ? {DW{1'b0}} : rdata)});
    @(posedge pclk); #2;
    req_valid = 1'b0;
    k = 0;
    done = 0;
    while (!done && k < 80) begin
      k++;
      if (psel != '0) obs_psel_or = obs_psel_or | psel;
      if ((psel != '0 && !$onehot(psel)) || (penable && psel == '0)) obs_psel_bad = 1;
      if (paddr !== addr || pwrite !== wr || pwdata !== wdata || pstrb !== strb || pprot !== prot)
        obs_bus_bad = 1;
      if (psel != '0 && !penable) obs_setup++;
      if (penable) begin
        obs_access++;
        pready = ~ssv | ((obs_access > wait_n) ? ssv : '0);
      end
      if (rsp_valid) begin
        if (obs_lat == 0) begin
          obs_lat = k;
          first_rsp = {rsp_err, rsp_rdata};
        end else if ({rsp_err, rsp_rdata} !== first_rsp) begin
          obs_rsp_unstable = 1;
        end
        obs_resp++;
        rsp_ready = (obs_resp > hold);
      end else if (obs_lat != 0) begin
        done = 1;
        rsp_ready = 1'b0;
      end
      if (!done) begin
        @(posedge pclk); #2;
      end
    end
    if (!done) obs_hang = 1;
    pready = '0;
    pslverr = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #2;
    total++;
    if ({psel, penable, rsp_valid, rsp_err} !== '0 || rsp_rdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got psel=%b en=%b vld=%b err=%b rdata=%h, required all 0",
               psel, penable, rsp_valid, rsp_err, rsp_rdata);
    end
    total++;
    if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || pprot !== '0 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus: got addr=%h wdata=%h strb=%h prot=%h wr=%b, required 0",
               paddr, pwdata, pstrb, pprot, pwrite);
    end
    presetn = 1'b1;
    @(posedge pclk); #2;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_req_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_read_fast();
    do_xfer(32'h0000_0010, 1'b0, 32'h1111_2222, 4'hF, 3'b010, 5'b00001, 0, 1'b0, 32'hDEAD_BEEF, 0);
    total++;
    if (obs_lat !== 3) begin bad++; $display("FAIL read_latency: got N+%0d, required N+3", obs_lat); end
    total++;
    if (obs_setup !== 1 || obs_access !== 1) begin
      bad++; $display("FAIL read_phases: got setup=%0d access=%0d, required 1 and 1", obs_setup, obs_access);
    end
    total++;
    if (obs_psel_or !== 5'b00001 || obs_psel_bad) begin
      bad++; $display("FAIL read_psel: got psel_or=%b bad=%0b, required 00001 and 0", obs_psel_or, obs_psel_bad);
    end
    total++;
    if (obs_resp !== 1 || obs_hang) begin
      bad++; $display("FAIL read_resp_cycles: got %0d hang=%0b, required 1 and 0", obs_resp, obs_hang);
    end
  endtask

  task automatic test_write_err_delay();
    do_xfer(32'h0003_0040, 1'b1, 32'hCAFE_F00D, 4'b0110, 3'b001, 5'b01000, 3, 1'b1, 32'h5555_AAAA, 2);
    total++;
    if (obs_access !== 4) begin bad++; $display("FAIL wr_access_cycles: got %0d, required 4", obs_access); end
    total++;
    if (obs_bus_bad) begin bad++; $display("FAIL wr_bus_stable: got unstable=1, required 0"); end
    total++;
    if (obs_lat !== 6 || obs_psel_or !== 5'b01000) begin
      bad++; $display("FAIL wr_latency_psel: got lat=%0d psel_or=%b, required 6 and 01000", obs_lat, obs_psel_or);
    end
    total++;
    if (obs_resp !== 3 || obs_rsp_unstable) begin
      bad++; $display("FAIL wr_resp_hold: got cycles=%0d unstable=%0b, required 3 and 0", obs_resp, obs_rsp_unstable);
    end
  endtask

  task automatic test_decerr_unmapped();
    do_xfer(32'h0005_0000, 1'b0, 32'h0, 4'hF, 3'b000, 5'b00000, 0, 1'b0, 32'h1234_5678, 0);
    total++;
    if (obs_lat !== 2) begin bad++; $display("FAIL decerr0_latency: got N+%0d, required N+2", obs_lat); end
    total++;
    if (obs_psel_or !== '0 || obs_access !== 0 || obs_psel_bad) begin
      bad++; $display("FAIL decerr0_psel: got psel_or=%b access=%0d, required 0 and 0", obs_psel_or, obs_access);
    end
  endtask

  task automatic test_decerr_overlap();
    do_xfer(32'h0002_0000, 1'b1, 32'h7777_7777, 4'hF, 3'b000, 5'b00110, 0, 1'b0, 32'h1234_5678, 1);
    total++;
    if (obs_lat !== 2) begin bad++; $display("FAIL decerr2_latency: got N+%0d, required N+2", obs_lat); end
    total++;
    if (obs_psel_or !== '0 || obs_access !== 0 || obs_psel_bad) begin
      bad++; $display("FAIL decerr2_psel: got psel_or=%b access=%0d, required 0 and 0", obs_psel_or, obs_access);
    end
  endtask

  task automatic test_timeout();
    do_xfer(32'h0001_0008, 1'b0, 32'h0, 4'hF, 3'b100, 5'b00010, 1000, 1'b0, 32'hABCD_0123, 0);
    total++;
    if (obs_access !== TO) begin bad++; $display("FAIL timeout_access: got %0d, required %0d", obs_access, TO); end
    total++;
    if (obs_lat !== TO + 2 || obs_hang) begin
      bad++; $display("FAIL timeout_latency: got N+%0d hang=%0b, required N+%0d", obs_lat, obs_hang, TO + 2);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 12; t++) begin
      int sl;
      int wn;
      logic [SN-1:0] sv;
      sl = $urandom_range(SN - 1, 0);
      wn = $urandom_range(4, 0);
      sv = '0;
      sv[sl] = 1'b1;
      do_xfer(AW'($urandom()), 1'($urandom_range(1, 0)), DW'($urandom()), 4'($urandom_range(15, 0)),
              3'($urandom_range(7, 0)), sv, wn, 1'($urandom_range(1, 0)), DW'($urandom()),
              $urandom_range(2, 0));
      total++;
      if (obs_access !== wn + 1 || obs_lat !== wn + 3 || obs_psel_or !== sv || obs_bus_bad) begin
        bad++;
        $display("FAIL b2b_%0d: got access=%0d lat=%0d psel_or=%b busbad=%0b, required %0d %0d %b 0",
                 t, obs_access, obs_lat, obs_psel_or, obs_bus_bad, wn + 1, wn + 3, sv);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int n;
    int guard;
    int seen_vld;
    // Leave rsp_err=1 and a nonzero rsp_rdata behind so the reset is visible.
    do_xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF, 3'b000, 5'b10000, 0, 1'b1, 32'h1234_5678, 0);
    @(posedge pclk); #2;
    req_addr = 32'h0004_0004; req_write = 1'b1; req_wdata = 32'h9999_8888;
    req_strb = 4'hF; req_prot = 3'b111; ss = 5'b00100; req_valid = 1'b1;
    pready = 5'b11011;
    pslverr = '0;
    @(posedge pclk); #2;
    req_valid = 1'b0;
    n = 0;
    guard = 0;
    while (n < 2 && guard < 20) begin
      if (penable) n++;
      if (n < 2) begin
        @(posedge pclk); #2;
      end
      guard++;
    end
    total++;
    if (n !== 2) begin bad++; $display("FAIL rst_mid_reach_access: got %0d access cycles, required 2", n); end
    presetn = 1'b0;
    @(posedge pclk); #2;
    total++;
    if ({psel, penable, rsp_valid, rsp_err} !== '0 || rsp_rdata !== '0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got psel=%b en=%b vld=%b err=%b rdata=%h, required all 0",
               psel, penable, rsp_valid, rsp_err, rsp_rdata);
    end
    total++;
    if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || pprot !== '0 || pwrite !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_bus: got addr=%h wdata=%h strb=%h prot=%h wr=%b, required 0",
               paddr, pwdata, pstrb, pprot, pwrite);
    end
    presetn = 1'b1;
    pready = '0;
    seen_vld = 0;
    repeat (4) begin
      @(posedge pclk); #2;
      if (rsp_valid) seen_vld++;
    end
    total++;
    if (seen_vld !== 0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_idle: got rsp_valid cycles=%0d req_ready=%b, required 0 and 1", seen_vld, req_ready);
    end
    do_xfer(32'h0000_0030, 1'b0, 32'h0, 4'hF, 3'b000, 5'b00100, 1, 1'b0, 32'h0BAD_CAFE, 0);
    total++;
    if (obs_lat !== 4 || obs_access !== 2) begin
      bad++; $display("FAIL rst_mid_new_xfer: got lat=%0d access=%0d, required 4 and 2", obs_lat, obs_access);
    end
  endtask

  initial begin
    test_reset();
    test_read_fast();
    test_write_err_delay();
    test_decerr_unmapped();
    test_decerr_overlap();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    repeat (3) @(posedge pclk);
    #2;
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL sb_drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
